// File: rtl/pipelined_multiport_rom.sv
// Multi-port read-only lookup table with a shared content constant; ROM_ADDR_CHECK_EN enables oError.
// Latency: gLatency cycles from request edge to oValid; full throughput, one request per port per cycle.
// Backpressure: iHold freezes every stage; requests presented while held are dropped.
module pipelined_multiport_rom #(
  parameter int gAddressWidth = 4,
  parameter int gDepth        = 16,
  parameter int gDataWidth    = 8,
  parameter int gPorts        = 2,
  parameter int gLatency      = 1,
  parameter logic [gDepth*gDataWidth-1:0] gContent = '0
) (
  input  logic                            iClock,
  input  logic                            iReset,
  input  logic [gPorts-1:0]               iRead,
  input  logic [gPorts*gAddressWidth-1:0] iAddress,
  input  logic                            iHold,
  output logic [gPorts-1:0]               oValid,
  output logic [gPorts*gDataWidth-1:0]    oData,
  output logic [gPorts-1:0]               oError
);

  localparam int cSlots = 1 << gAddressWidth;

  typedef struct packed {
    logic                  valid;
    logic                  error;
    logic [gDataWidth-1:0] data;
  } stage_t;

  // Slots past gDepth read as zero, so any address indexes safely.
  logic [gDataWidth-1:0] rom [cSlots];

  for (genvar k = 0; k < cSlots; k++) begin : gRom
    if (k < gDepth) begin : gWord
      assign rom[k] = gContent[k*gDataWidth +: gDataWidth];
    end else begin : gPad
      assign rom[k] = '0;
    end
  end

  logic [gDataWidth-1:0] lookupData [gPorts];
  logic [gPorts-1:0]     lookupErr;
  stage_t                stage [gPorts][gLatency];

  for (genvar p = 0; p < gPorts; p++) begin : gPort
    logic [gAddressWidth-1:0] addr;
    assign addr          = iAddress[p*gAddressWidth +: gAddressWidth];
    assign lookupData[p] = rom[addr];
`ifdef ROM_ADDR_CHECK_EN
    localparam logic [gAddressWidth:0] cDepth = (gAddressWidth+1)'(gDepth);
    assign lookupErr[p] = ({1'b0, addr} >= cDepth);
`else
    assign lookupErr[p] = 1'b0;
`endif
    assign oValid[p]                          = stage[p][gLatency-1].valid;
    assign oError[p]                          = stage[p][gLatency-1].error;
    assign oData[p*gDataWidth +: gDataWidth]  = stage[p][gLatency-1].data;
  end

  always_ff @(posedge iClock) begin
    if (iReset) begin
      for (int p = 0; p < gPorts; p++) begin
        for (int s = 0; s < gLatency; s++) begin
          stage[p][s] <= '0;
        end
      end
    end else if (!iHold) begin
      for (int p = 0; p < gPorts; p++) begin
        stage[p][0].valid <= iRead[p];
        stage[p][0].error <= iRead[p] & lookupErr[p];
        if (iRead[p]) stage[p][0].data <= lookupData[p];
        // Data only moves with a valid token, so idle outputs keep the last word.
        for (int s = 1; s < gLatency; s++) begin
          stage[p][s].valid <= stage[p][s-1].valid;
          stage[p][s].error <= stage[p][s-1].error;
          if (stage[p][s-1].valid) stage[p][s].data <= stage[p][s-1].data;
        end
      end
    end
  end

endmodule

// File: tb/tb_pipelined_multiport_rom.sv
// Bench: four latency variants (depth 16) plus a depth-12 range variant, all sharing one stimulus.
module tb_pipelined_multiport_rom;

  function automatic logic [127:0] mkContent();
    logic [127:0] r;
    r = '0;
    for (int k = 0; k < 16; k++) r[k*8 +: 8] = 8'(k * 3);
    return r;
  endfunction

  localparam logic [127:0] cContent16 = mkContent();
  localparam logic [95:0]  cContent12 = cContent16[95:0];

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] rd = '0;
  logic [7:0] addrBus = '0;
  logic       hold = 1'b0;

  logic [1:0]  outV [5];
  logic [15:0] outD [5];
  logic [1:0]  outE [5];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : gLat
    pipelined_multiport_rom #(
      .gAddressWidth(4), .gDepth(16), .gDataWidth(8), .gPorts(2),
      .gLatency(g + 1), .gContent(cContent16)
    ) u_dut (
      .iClock(clk), .iReset(rst), .iRead(rd), .iAddress(addrBus), .iHold(hold),
      .oValid(outV[g]), .oData(outD[g]), .oError(outE[g])
    );
  end

  pipelined_multiport_rom #(
    .gAddressWidth(4), .gDepth(12), .gDataWidth(8), .gPorts(2),
    .gLatency(1), .gContent(cContent12)
  ) u_range (
    .iClock(clk), .iReset(rst), .iRead(rd), .iAddress(addrBus), .iHold(hold),
    .oValid(outV[4]), .oData(outD[4]), .oError(outE[4])
  );

  // Reference model: a history of accepted (non-held) edges. A variant of latency L
  // shows, after accepted edge m, the request taken at accepted edge m-(L-1), unless
  // a reset edge happened at or after that request.
  int         nChecks = 0;
  int         nFails  = 0;
  int         activeCnt = 0;
  int         resetMark = 0;
  logic       histRead [2][8192];
  logic [3:0] histAddr [2][8192];
  logic       expV [5][2];
  logic [7:0] expD [5][2];
  logic       expE [5][2];
  logic [7:0] lastD [5][2];

  function automatic int latOf(int i);
    return (i < 4) ? i + 1 : 1;
  endfunction

  function automatic int depthOf(int i);
    return (i < 4) ? 16 : 12;
  endfunction

  task automatic tick(input logic [1:0] r, input logic [3:0] a0, input logic [3:0] a1,
                      input logic h, input logic rs);
    int n;
    rd = r; addrBus = {a1, a0}; hold = h; rst = rs;
    @(posedge clk);
    if (rs) begin
      activeCnt++;
      histRead[0][activeCnt] = 1'b0;
      histRead[1][activeCnt] = 1'b0;
      resetMark = activeCnt;
    end else if (!h) begin
      activeCnt++;
      histRead[0][activeCnt] = r[0]; histAddr[0][activeCnt] = a0;
      histRead[1][activeCnt] = r[1]; histAddr[1][activeCnt] = a1;
    end
    for (int i = 0; i < 5; i++) begin
      for (int p = 0; p < 2; p++) begin
        n = activeCnt - (latOf(i) - 1);
        expV[i][p] = (n > resetMark) && histRead[p][n];
        expE[i][p] = 1'b0;
        if (rs && (resetMark == activeCnt)) lastD[i][p] = 8'd0;
        if (expV[i][p]) begin
          if (int'(histAddr[p][n]) < depthOf(i)) begin
            lastD[i][p] = 8'(int'(histAddr[p][n]) * 3);
          end else begin
            lastD[i][p] = 8'd0;
`ifdef ROM_ADDR_CHECK_EN
            expE[i][p] = 1'b1;
`endif
          end
        end
        expD[i][p] = lastD[i][p];
      end
    end
    #1;
  endtask

  task automatic test_reset();
    for (int c = 0; c < 3; c++) begin
      if (c < 2) tick(2'b11, 4'd5, 4'd5, 1'b1, 1'b1);
      else       tick(2'b00, 4'd0, 4'd0, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) begin
        nChecks++;
        if (outV[i] !== 2'b00 || outD[i] !== 16'h0 || outE[i] !== 2'b00) begin
          nFails++;
          $display("FAIL reset inst%0d cyc%0d: v=%b d=%h e=%b, required all zero", i, c, outV[i], outD[i], outE[i]);
        end
      end
    end
  endtask

  task automatic test_latency_sweep();
    int seen [4];
    for (int i = 0; i < 4; i++) seen[i] = 0;
    tick(2'b01, 4'd5, 4'd0, 1'b0, 1'b0);
    for (int c = 1; c <= 6; c++) begin
      for (int i = 0; i < 4; i++) begin
        nChecks++;
        if (outV[i][0] !== (c == i + 1)) begin
          nFails++;
          $display("FAIL latency L%0d cyc%0d: valid=%b, required %b", i + 1, c, outV[i][0], (c == i + 1));
        end
        if (outV[i][0] === 1'b1) begin
          seen[i]++;
          nChecks++;
          if (outD[i][7:0] !== 8'd15) begin
            nFails++;
            $display("FAIL latency_data L%0d: data=%0d, required 15", i + 1, outD[i][7:0]);
          end
        end
      end
      tick(2'b00, 4'd0, 4'd0, 1'b0, 1'b0);
    end
    for (int i = 0; i < 4; i++) begin
      nChecks++;
      if (seen[i] != 1) begin
        nFails++;
        $display("FAIL latency_pulse L%0d: pulses=%0d, required 1", i + 1, seen[i]);
      end
    end
  endtask

  task automatic test_multiport();
    tick(2'b11, 4'd7, 4'd7, 1'b0, 1'b0);
    nChecks++;
    if (outV[0] !== 2'b11 || outD[0] !== {8'd21, 8'd21}) begin
      nFails++;
      $display("FAIL multiport_same: v=%b d=%h, required 11 1515", outV[0], outD[0]);
    end
    tick(2'b11, 4'd2, 4'd9, 1'b0, 1'b0);
    nChecks++;
    if (outV[0] !== 2'b11 || outD[0] !== {8'd27, 8'd6}) begin
      nFails++;
      $display("FAIL multiport_b2b: v=%b d=%h, required 11 1b06", outV[0], outD[0]);
    end
    tick(2'b00, 4'd0, 4'd0, 1'b0, 1'b0);
    nChecks++;
    if (outV[0] !== 2'b00 || outD[0] !== {8'd27, 8'd6} || outE[0] !== 2'b00) begin
      nFails++;
      $display("FAIL multiport_retain: v=%b d=%h e=%b, required 00 1b06 00", outV[0], outD[0], outE[0]);
    end
  endtask

  task automatic test_hold();
    logic [7:0] got [$];
    logic [1:0] fv;
    logic [15:0] fd;
    tick(2'b01, 4'd1, 4'd0, 1'b0, 1'b0);
    tick(2'b01, 4'd2, 4'd0, 1'b0, 1'b0);
    fv = outV[2]; fd = outD[2];
    for (int c = 0; c < 4; c++) begin
      tick(2'b01, 4'd3, 4'd0, 1'b1, 1'b0);
      nChecks++;
      if (outV[2] !== fv || outD[2] !== fd) begin
        nFails++;
        $display("FAIL hold_frozen cyc%0d: v=%b d=%h, required v=%b d=%h", c, outV[2], outD[2], fv, fd);
      end
    end
    for (int c = 0; c < 5; c++) begin
      tick(2'b00, 4'd0, 4'd0, 1'b0, 1'b0);
      if (outV[2][0] === 1'b1) got.push_back(outD[2][7:0]);
    end
    nChecks++;
    if (got.size() != 2 || got[0] !== 8'd3 || got[1] !== 8'd6) begin
      nFails++;
      $display("FAIL hold_emerge: count=%0d first=%0d second=%0d, required 2 words 3 then 6",
               got.size(), (got.size() > 0) ? got[0] : 8'hff, (got.size() > 1) ? got[1] : 8'hff);
    end
  endtask

  task automatic test_range();
    logic errReq;
`ifdef ROM_ADDR_CHECK_EN
    errReq = 1'b1;
`else
    errReq = 1'b0;
`endif
    tick(2'b11, 4'd13, 4'd11, 1'b0, 1'b0);
    nChecks++;
    if (outV[4] !== 2'b11 || outD[4] !== {8'd33, 8'd0} || outE[4] !== {1'b0, errReq}) begin
      nFails++;
      $display("FAIL range: v=%b d=%h e=%b, required 11 2100 %b", outV[4], outD[4], outE[4], {1'b0, errReq});
    end
    nChecks++;
    if (outV[0] !== 2'b11 || outD[0] !== {8'd33, 8'd39} || outE[0] !== 2'b00) begin
      nFails++;
      $display("FAIL range_full_depth: v=%b d=%h e=%b, required 11 2127 00", outV[0], outD[0], outE[0]);
    end
    tick(2'b00, 4'd0, 4'd0, 1'b0, 1'b0);
  endtask

  task automatic test_reset_midflight();
    int rises;
    rises = 0;
    tick(2'b01, 4'd4, 4'd0, 1'b0, 1'b0);
    tick(2'b01, 4'd5, 4'd0, 1'b0, 1'b0);
    tick(2'b00, 4'd0, 4'd0, 1'b0, 1'b1);
    tick(2'b01, 4'd6, 4'd0, 1'b0, 1'b0);
    for (int c = 0; c < 6; c++) begin
      tick(2'b00, 4'd0, 4'd0, 1'b0, 1'b0);
      if (outV[3][0] === 1'b1) begin
        rises++;
        nChecks++;
        if (c != 2 || outD[3][7:0] !== 8'd18) begin
          nFails++;
          $display("FAIL midflight_data: cyc%0d data=%0d, required cyc2 data 18", c, outD[3][7:0]);
        end
      end
    end
    nChecks++;
    if (rises != 1) begin
      nFails++;
      $display("FAIL midflight_count: deliveries=%0d, required 1", rises);
    end
  endtask

  task automatic test_random();
    logic h, rs;
    for (int c = 0; c < 300; c++) begin
      h  = ($urandom_range(0, 4) == 0);
      rs = ($urandom_range(0, 49) == 0);
      tick(2'($urandom), 4'($urandom), 4'($urandom), h, rs);
      for (int i = 0; i < 5; i++) begin
        for (int p = 0; p < 2; p++) begin
          nChecks++;
          if (outV[i][p] !== expV[i][p] || outD[i][p*8 +: 8] !== expD[i][p] || outE[i][p] !== expE[i][p]) begin
            nFails++;
            $display("FAIL random cyc%0d inst%0d p%0d: v=%b d=%0d e=%b, required v=%b d=%0d e=%b",
                     c, i, p, outV[i][p], outD[i][p*8 +: 8], outE[i][p], expV[i][p], expD[i][p], expE[i][p]);
          end
        end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 5; i++) begin
      for (int p = 0; p < 2; p++) lastD[i][p] = 8'd0;
    end
    for (int p = 0; p < 2; p++) begin
      for (int n = 0; n < 8192; n++) begin
        histRead[p][n] = 1'b0;
        histAddr[p][n] = 4'd0;
      end
    end
    @(negedge clk);
    test_reset();
    test_latency_sweep();
    test_multiport();
    test_hold();
    test_range();
    test_reset_midflight();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
